// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM states and the baud divisor table.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Clk cycles per oversample tick at 50 MHz, i.e. round(50e6 / (16 * baud)).
    function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] code);
        case (code)
            3'b000:  return DIV_W'(10417);
            3'b001:  return DIV_W'(2604);
            3'b010:  return DIV_W'(651);
            3'b011:  return DIV_W'(326);
            3'b100:  return DIV_W'(163);
            3'b101:  return DIV_W'(81);
            3'b110:  return DIV_W'(54);
            default: return DIV_W'(27);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// Oversample tick generator: one-cycle sample_ENABLE pulse every N Clk cycles.
// clear holds the divider at zero so the first tick lands exactly N cycles later.
module uart_baud_controller
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       clear,
    output logic       sample_ENABLE
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div;

    assign div           = baud_divisor(baud_select);
    assign sample_ENABLE = !clear && (cnt_q == div - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear || sample_ENABLE)
            cnt_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits, even parity, one stop bit, 16x oversampled bit timing.
// Data and baud code are latched on an accepted write and held for the whole frame.
module uart_transmitter
    import uart_pkg::*;
(
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic [2:0]           baud_select,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    output logic                 TxD,
    output logic                 Tx_BUSY
);

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           baud_q, baud_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 sample_en;
    logic                 bit_done;
    logic                 accept;

    // Divider is parked at zero while idle, so the start bit is a full 16*N cycles.
    uart_baud_controller u_baud (
        .Clk          (Clk),
        .reset        (reset),
        .baud_select  (baud_q),
        .clear        (state_q == IDLE),
        .sample_ENABLE(sample_en)
    );

    assign accept   = Tx_WR && Tx_EN && !busy_q;
    assign bit_done = sample_en && (tick_q == TICK_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        data_d  = data_q;
        baud_d  = baud_q;

        if (state_q != IDLE && sample_en)
            tick_d = bit_done ? '0 : tick_q + TICK_W'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    data_d  = Tx_DATA;
                    baud_d  = baud_select;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_done)
                    state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done)
                    state_d = STOP;
            end
            STOP: begin
                if (bit_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so TxD comes straight from a flop.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_d[idx_d];
            PARITY:  txd_d = ^data_d;
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            baud_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame content, exact bit timing, write
// acceptance rules, back-to-back frames and reset behaviour.
module tb_uart_transmitter;

    logic       Clk = 1'b0;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic       TxD;
    logic       Tx_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    uart_transmitter dut (
        .Clk        (Clk),
        .reset      (reset),
        .Tx_DATA    (Tx_DATA),
        .baud_select(baud_select),
        .Tx_EN      (Tx_EN),
        .Tx_WR      (Tx_WR),
        .TxD        (TxD),
        .Tx_BUSY    (Tx_BUSY)
    );

    always #10 Clk = ~Clk;

    // Called at a negedge; the write is taken on the following posedge.
    task automatic drive_write(input logic [7:0] d, input logic [2:0] b);
        Tx_DATA     = d;
        baud_select = b;
        Tx_WR       = 1'b1;
        @(posedge Clk);
        #1 Tx_WR = 1'b0;
    endtask

    // Samples TxD at the first, middle and last cycle of each bit slot, counting
    // Tx_BUSY-high cycles. Cycle 0 is the first cycle after the accepting edge.
    // At cycle wr_at a write of 0xFF at baud 000 is attempted and inputs are left changed.
    task automatic capture(input int p, input int nbits, input int wr_at,
                           output logic [10:0] fb, output logic [10:0] mb,
                           output logic [10:0] lb, output int busy_hi);
        fb = '1; mb = '1; lb = '1; busy_hi = 0;
        for (int c = 0; c < nbits * p; c++) begin
            @(negedge Clk);
            if (c % p == 0)     fb[c / p] = TxD;
            if (c % p == p / 2) mb[c / p] = TxD;
            if (c % p == p - 1) lb[c / p] = TxD;
            if (Tx_BUSY) busy_hi++;
            if (c == wr_at) begin
                Tx_WR = 1'b1; Tx_DATA = 8'hFF; baud_select = 3'b000;
            end else if (c == wr_at + 1) begin
                Tx_WR = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; Tx_EN = 1'b1; Tx_WR = 1'b0; Tx_DATA = 8'h00; baud_select = 3'b111;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, expected 1", TxD); end
        n_checks++;
        if (Tx_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", Tx_BUSY); end
        reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_frame_2b;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'h2B, 3'b111);
        capture(432, 11, -1, fb, mb, lb, bh);
        n_checks++;
        if (mb !== 11'h456) begin n_fail++; $display("FAIL f2b_mid: got %h, expected 456", mb); end
        n_checks++;
        if (fb !== 11'h456) begin n_fail++; $display("FAIL f2b_first: got %h, expected 456", fb); end
        n_checks++;
        if (lb !== 11'h456) begin n_fail++; $display("FAIL f2b_last: got %h, expected 456", lb); end
        n_checks++;
        if (bh !== 4752) begin n_fail++; $display("FAIL f2b_busy_cycles: got %0d, expected 4752", bh); end
        @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b01) begin n_fail++; $display("FAIL f2b_end: got busy,txd=%b, expected 01", {Tx_BUSY, TxD}); end
    endtask

    // Tx_EN dropped right after the write must not truncate the frame.
    task automatic test_loopback_51;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'h51, 3'b111);
        Tx_EN = 1'b0;
        capture(432, 11, -1, fb, mb, lb, bh);
        n_checks++;
        if (mb !== 11'h6A2) begin n_fail++; $display("FAIL f51_mid: got %h, expected 6a2", mb); end
        n_checks++;
        if (bh !== 4752) begin n_fail++; $display("FAIL f51_busy_cycles: got %0d, expected 4752", bh); end
        n_checks++;
        if (mb[8:1] !== 8'h51) begin n_fail++; $display("FAIL rx_data: got %h, expected 51", mb[8:1]); end
        n_checks++;
        if (mb[0] !== 1'b0) begin n_fail++; $display("FAIL rx_valid: start bit got %b, expected 0", mb[0]); end
        n_checks++;
        if ((mb[9] ^ (^mb[8:1])) !== 1'b0) begin n_fail++; $display("FAIL rx_perror: got 1, expected 0"); end
        n_checks++;
        if (mb[10] !== 1'b1) begin n_fail++; $display("FAIL rx_ferror: stop bit got %b, expected 1", mb[10]); end
        @(negedge Clk);
        Tx_EN = 1'b1;
    endtask

    task automatic test_wr_ignored;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'h2B, 3'b111);
        capture(432, 11, 1000, fb, mb, lb, bh);
        n_checks++;
        if (mb !== 11'h456) begin n_fail++; $display("FAIL ign_mid: got %h, expected 456", mb); end
        n_checks++;
        if (lb !== 11'h456) begin n_fail++; $display("FAIL ign_last: got %h, expected 456", lb); end
        n_checks++;
        if (bh !== 4752) begin n_fail++; $display("FAIL ign_busy_cycles: got %0d, expected 4752", bh); end
        @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b01) begin n_fail++; $display("FAIL ign_end: got busy,txd=%b, expected 01", {Tx_BUSY, TxD}); end
        repeat (20) @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b01) begin n_fail++; $display("FAIL ign_no_queue: got busy,txd=%b, expected 01", {Tx_BUSY, TxD}); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'h00, 3'b111);
        capture(432, 11, -1, fb, mb, lb, bh);
        n_checks++;
        if (mb !== 11'h400) begin n_fail++; $display("FAIL b2b_first_frame: got %h, expected 400", mb); end
        @(negedge Clk);
        n_checks++;
        if (Tx_BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: got %b, expected 0", Tx_BUSY); end
        drive_write(8'hFF, 3'b111);
        capture(432, 11, -1, fb, mb, lb, bh);
        n_checks++;
        if (fb !== 11'h5FE) begin n_fail++; $display("FAIL b2b_second_first: got %h, expected 5fe", fb); end
        n_checks++;
        if (mb !== 11'h5FE) begin n_fail++; $display("FAIL b2b_second_mid: got %h, expected 5fe", mb); end
        n_checks++;
        if (bh !== 4752) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d, expected 4752", bh); end
        @(negedge Clk);
    endtask

    task automatic test_frame_a5;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'hA5, 3'b111);
        capture(432, 11, -1, fb, mb, lb, bh);
        n_checks++;
        if (mb !== 11'h54A) begin n_fail++; $display("FAIL fa5_mid: got %h, expected 54a", mb); end
        @(negedge Clk);
    endtask

    task automatic test_tx_en_low;
        int bad = 0;
        Tx_EN = 1'b0;
        Tx_DATA = 8'h00;
        Tx_WR = 1'b1;
        @(negedge Clk);
        Tx_WR = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL en_low_write: got %0d active cycles, expected 0", bad); end
        Tx_EN = 1'b1;
    endtask

    task automatic test_reset_midframe;
        drive_write(8'h00, 3'b111);
        repeat (2000) @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b10) begin n_fail++; $display("FAIL rst_pre: got busy,txd=%b, expected 10", {Tx_BUSY, TxD}); end
        reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b01) begin n_fail++; $display("FAIL rst_abort: got busy,txd=%b, expected 01", {Tx_BUSY, TxD}); end
        @(negedge Clk);
        reset       = 1'b1;
        Tx_DATA     = 8'h2B;
        baud_select = 3'b111;
        Tx_WR       = 1'b1;
        @(posedge Clk);
        #1 Tx_WR = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({Tx_BUSY, TxD} !== 2'b10) begin n_fail++; $display("FAIL rst_first_write: got busy,txd=%b, expected 10", {Tx_BUSY, TxD}); end
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_baud_9600;
        logic [10:0] fb, mb, lb; int bh;
        drive_write(8'hA5, 3'b011);
        capture(5216, 3, -1, fb, mb, lb, bh);
        n_checks++;
        if (fb[2:0] !== 3'b010) begin n_fail++; $display("FAIL b9600_first: got %b, expected 010", fb[2:0]); end
        n_checks++;
        if (lb[2:0] !== 3'b010) begin n_fail++; $display("FAIL b9600_last: got %b, expected 010", lb[2:0]); end
        n_checks++;
        if (bh !== 15648) begin n_fail++; $display("FAIL b9600_busy_cycles: got %0d, expected 15648", bh); end
        @(negedge Clk);
        n_checks++;
        if (TxD !== 1'b1) begin n_fail++; $display("FAIL b9600_bit3_edge: got %b, expected 1", TxD); end
        reset = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        test_reset;
        test_frame_2b;
        test_loopback_51;
        test_wr_ignored;
        test_back_to_back;
        test_frame_a5;
        test_tx_en_low;
        test_reset_midframe;
        test_baud_9600;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have port Clk, input, 1, system clock (50 MHz).
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port Tx_DATA, input, 8, byte to transmit.
REQ-004 SHALL have port baud_select, input, 3, rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-005 SHALL have port Tx_EN, input, 1, transmitter enable.
REQ-006 SHALL have port Tx_WR, input, 1, write strobe, one cycle.
REQ-007 SHALL have port TxD, output, 1, serial line, idle high.
REQ-008 SHALL have port Tx_BUSY, output, 1, frame in progress.

Function
REQ-009 SHALL emit an 11-bit frame on TxD in this order: start bit (0), Tx_DATA[0] through Tx_DATA[7] (LSB first), even parity bit (XOR of the 8 data bits), stop bit (1).
REQ-010 SHALL derive the oversample tick from the latched baud_select as one Clk pulse every N cycles, with N = 10417, 2604, 651, 326, 163, 81, 54, 27 for codes 000..111.
REQ-011 SHALL hold each frame bit for exactly 16 oversample ticks (16*N Clk cycles; 432 cycles at 115200 baud).
REQ-012 SHALL use the states IDLE, START, DATA, PARITY and STOP; DATA SHALL count 8 bits with a 3-bit index.
REQ-013 SHALL accept a write only when Tx_WR=1, Tx_EN=1 and Tx_BUSY=0 in the same cycle; Tx_DATA and baud_select SHALL be latched in that cycle.
REQ-014 SHALL ignore Tx_WR while Tx_BUSY=1 or Tx_EN=0, with no queuing.
REQ-015 SHALL assert Tx_BUSY and drive TxD=0 in the cycle after an accepted write, and SHALL clear the oversample divider in that same cycle so the start bit is exactly 16*N cycles long.
REQ-016 SHALL deassert Tx_BUSY and return to IDLE in the cycle after the 16th tick of the stop bit; a write in that following cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-017 SHALL let the current frame complete when Tx_EN falls mid-frame, with no truncation.
REQ-018 SHALL ignore changes to Tx_DATA or baud_select during a frame until the next accepted write.
REQ-019 SHALL drive TxD=1 whenever in IDLE, regardless of Tx_EN.
REQ-020 SHALL register TxD, with no combinational path from any input to TxD.
REQ-021 SHALL treat reserved or undefined baud behaviour as impossible, since all 8 codes are defined.

Reset
REQ-022 SHALL, when reset=0 at a rising Clk edge, force state to IDLE, TxD=1, Tx_BUSY=0, bit index=0, divider count=0 and latched data=0.
REQ-023 SHALL abort a frame on reset asserted mid-frame, with TxD returning to 1 in the next cycle and no partial stop bit.
REQ-024 SHALL accept a new write in the first cycle after reset returns to 1.

Structure
REQ-025 SHALL take the following from shared package uart_pkg: the baud divisor table, the frame constants (DATA_BITS=8, OVERSAMPLE=16) and the state enumeration; uart_pkg SHALL also be used by the receiver.
REQ-026 SHALL instantiate sub-module uart_baud_controller (inputs baud_select, clear; output sample_ENABLE), shared with the receiver.
REQ-027 SHALL contain no other sub-modules.

Verification
REQ-028 SHALL cover: baud 111, write 0x2B -> TxD sequence 0,1,1,0,1,0,1,0,0,0(parity),1, each bit 432 cycles; Tx_BUSY high 4752 cycles.
REQ-029 SHALL cover: baud 111, write 0x51 -> data bits 1,0,0,0,1,0,1,0, parity 1, stop 1; a uart_receiver loopback SHALL output Rx_DATA=0x51, Rx_VALID=1, Rx_PERROR=0, Rx_FERROR=0.
REQ-030 SHALL cover: Tx_WR pulsed again with 0xFF 1000 cycles into a 0x2B frame -> ignored; only 0x2B is sent; TxD=1 after the stop bit.
REQ-031 SHALL cover: write 0x00 then 0xFF in the first cycle after Tx_BUSY falls -> two contiguous frames, second frame parity 0, no idle gap.
REQ-032 SHALL cover: Tx_EN=0 with a Tx_WR pulse -> Tx_BUSY stays 0 and TxD stays 1; separately, reset=0 at cycle 2000 of a frame -> TxD=1 and Tx_BUSY=0 on the next edge.
REQ-033 SHALL cover: baud 011 (9600), write 0xA5 -> bit period 5216 cycles (16*326), parity 0.
